// File: rtl/seq_datapath_pkg.sv
// Shared types for the self-sequencing register/ALU datapath.
package seq_datapath_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDA  = 3'd1,
    ST_RDB  = 3'd2,
    ST_EXE  = 3'd3,
    ST_WB   = 3'd4
  } dp_state_e;

  // Width-independent part of a latched operation; addresses and immediate
  // are held beside it because their widths follow the module parameters.
  typedef struct packed {
    alu_op_e aluop;
    shift_e  shift;
    logic    use_imm;
    logic    zero_a;
    logic    wb_en;
  } op_ctrl_t;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: ADD, SUB, AND, NOT B with {N, V, Z} flags.
module dp_alu
  import seq_datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] op_a,
  input  logic signed [WIDTH-1:0] op_b,
  input  alu_op_e                 aluop,
  output logic signed [WIDTH-1:0] alu_out,
  output logic [2:0]              flags
);

  logic ovf;

  always_comb begin
    alu_out = '0;
    ovf     = 1'b0;
    unique case (aluop)
      ALU_ADD: begin
        alu_out = op_a + op_b;
        ovf     = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_out[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_out = op_a - op_b;
        ovf     = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_out[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_AND: alu_out = op_a & op_b;
      ALU_NOT: alu_out = ~op_b;
      default: alu_out = '0;
    endcase
  end

  assign flags = {alu_out[WIDTH-1], ovf, (alu_out == '0)};

endmodule

// File: rtl/seq_datapath.sv
// Register file, operand registers, shifter and ALU sequenced by a
// five-state FSM that runs one register-to-register op per start/done.
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter int  WIDTH      = 16,
  parameter int  SIZE       = 8,
  localparam int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [ADDR_WIDTH-1:0] rn,
  input  logic [ADDR_WIDTH-1:0] rm,
  input  logic [1:0]            aluop,
  input  logic [1:0]            shift,
  input  logic                  use_imm,
  input  logic                  zero_a,
  input  logic                  wb_en,
  input  logic [WIDTH-1:0]      imm,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [WIDTH-1:0]      ext_data,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic [2:0]            status,
  output logic [WIDTH-1:0]      dbg_data
);

  dp_state_e state_q, state_d;

  op_ctrl_t              op_q;
  logic [ADDR_WIDTH-1:0] rd_q, rn_q, rm_q;
  logic [WIDTH-1:0]      imm_q;

  logic [WIDTH-1:0]        rf [SIZE];
  logic signed [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0]        c_q;
  logic [2:0]              status_q;

  logic signed [WIDTH-1:0] op_a, op_b, alu_out;
  logic [2:0]              flags;

  function automatic logic signed [WIDTH-1:0] shift_b(input logic signed [WIDTH-1:0] v,
                                                      input shift_e s);
    logic signed [WIDTH-1:0] r;
    unique case (s)
      SH_LSL1: r = v <<< 1;
      SH_LSR1: r = $signed($unsigned(v) >> 1);
      SH_ASR1: r = v >>> 1;
      default: r = v;
    endcase
    return r;
  endfunction

  // Sequencer: only IDLE waits on start, every other state advances.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RDA;
      ST_RDA:  state_d = ST_RDB;
      ST_RDB:  state_d = ST_EXE;
      ST_EXE:  state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Operation latch: captured only when a start is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      op_q.aluop   <= alu_op_e'(aluop);
      op_q.shift   <= shift_e'(shift);
      op_q.use_imm <= use_imm;
      op_q.zero_a  <= zero_a;
      op_q.wb_en   <= wb_en;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start) begin
      rd_q  <= rd;
      rn_q  <= rn;
      rm_q  <= rm;
      imm_q <= imm;
    end
  end

  // Operand select and execute.
  assign op_a = op_q.zero_a  ? '0 : a_q;
  assign op_b = op_q.use_imm ? $signed(imm_q) : shift_b(b_q, op_q.shift);

  dp_alu #(.WIDTH(WIDTH)) u_alu (
    .op_a    (op_a),
    .op_b    (op_b),
    .aluop   (op_q.aluop),
    .alu_out (alu_out),
    .flags   (flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      unique case (state_q)
        ST_RDA:  a_q <= rf[rn_q];
        ST_RDB:  b_q <= rf[rm_q];
        ST_EXE: begin
          c_q      <= alu_out;
          status_q <= flags;
        end
        default: ;
      endcase
    end
  end

  // Register file: internal writeback is ordered last so it wins a same-address clash.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) rf[i] <= '0;
    end else begin
      if (ext_we) rf[ext_addr] <= ext_data;
      if (state_q == ST_WB && op_q.wb_en) rf[rd_q] <= c_q;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_WB);
  assign result   = c_q;
  assign status   = status_q;
  assign dbg_data = rf[dbg_addr];

endmodule
